// File: rtl/csr_file.sv
// Machine-mode CSR file: applies writeback CSR writes, runs counters, handles trap/interrupt entry and MRET.
// Latency: state updates at the edge the inputs are presented; read port is combinational; redirect is 1 cycle.
// No backpressure: every presented writeback is consumed in its cycle; redirect is a single-cycle pulse.
module csr_file #(
   parameter logic [31:0] HART_ID    = 32'd0,
   parameter logic [31:0] MISA_VALUE = 32'h40000100
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        interrupt,
   input  logic        memoryWritebackValid,
   input  logic        dualValid,
   input  logic [11:0] destinationCSR,
   input  logic        csrDestinationEnable,
   input  logic [31:0] csrWriteData,
   // trapData layout: [69:68] trapType, [67:64] cause, [63:32] pc, [31:0] tval
   input  logic [69:0] trapData,
   input  logic [11:0] readCSR,
   output logic [31:0] readData,
   output logic        redirectValid,
   output logic [31:0] redirectPC
);

   // CSR address map
   localparam logic [11:0] A_MSTATUS   = 12'h300;
   localparam logic [11:0] A_MISA      = 12'h301;
   localparam logic [11:0] A_MIE       = 12'h304;
   localparam logic [11:0] A_MTVEC     = 12'h305;
   localparam logic [11:0] A_MSCRATCH  = 12'h340;
   localparam logic [11:0] A_MEPC      = 12'h341;
   localparam logic [11:0] A_MCAUSE    = 12'h342;
   localparam logic [11:0] A_MTVAL     = 12'h343;
   localparam logic [11:0] A_MIP       = 12'h344;
   localparam logic [11:0] A_MCYCLE    = 12'hB00;
   localparam logic [11:0] A_MINSTRET  = 12'hB02;
   localparam logic [11:0] A_MCYCLEH   = 12'hB80;
   localparam logic [11:0] A_MINSTRETH = 12'hB82;
   localparam logic [11:0] A_MHARTID   = 12'hF14;

   // trapType encoding
   localparam logic [1:0] T_NONE      = 2'd0;
   localparam logic [1:0] T_EXCEPTION = 2'd1;
   localparam logic [1:0] T_MRET      = 2'd2;

   localparam logic [31:0] IRQ_CAUSE = 32'h8000000B;

   // trap payload fields
   logic [1:0]  trap_type;
   logic [3:0]  trap_cause;
   logic [31:0] trap_pc;
   logic [31:0] trap_tval;

   assign trap_type  = trapData[69:68];
   assign trap_cause = trapData[67:64];
   assign trap_pc    = trapData[63:32];
   assign trap_tval  = trapData[31:0];

   // architectural state; low bits that always read zero are not stored
   logic        mstatus_mie;
   logic        mstatus_mpie;
   logic        mie_meie;
   logic [29:0] mtvec_base;
   logic [29:0] mepc_word;
   logic [31:0] mcause;
   logic [31:0] mtval;
   logic [31:0] mscratch;
   logic [63:0] mcycle;
   logic [63:0] minstret;

   // pc of the instruction after the retiring one, word aligned
   logic [29:0] next_pc_word;
   assign next_pc_word = trap_pc[31:2] + 30'd1;

   // pc bits [1:0] never reach a register since mepc is word aligned
   logic unused_pc_bits;
   assign unused_pc_bits = ^trap_pc[1:0];

   // software write strobes, one per implemented writable CSR
   logic wr_mstatus;
   logic wr_mie;
   logic wr_mtvec;
   logic wr_mscratch;
   logic wr_mepc;
   logic wr_mcause;
   logic wr_mtval;
   logic wr_mcycle;
   logic wr_mcycleh;
   logic wr_minstret;
   logic wr_minstreth;

   assign wr_mstatus   = csrDestinationEnable && (destinationCSR == A_MSTATUS);
   assign wr_mie       = csrDestinationEnable && (destinationCSR == A_MIE);
   assign wr_mtvec     = csrDestinationEnable && (destinationCSR == A_MTVEC);
   assign wr_mscratch  = csrDestinationEnable && (destinationCSR == A_MSCRATCH);
   assign wr_mepc      = csrDestinationEnable && (destinationCSR == A_MEPC);
   assign wr_mcause    = csrDestinationEnable && (destinationCSR == A_MCAUSE);
   assign wr_mtval     = csrDestinationEnable && (destinationCSR == A_MTVAL);
   assign wr_mcycle    = csrDestinationEnable && (destinationCSR == A_MCYCLE);
   assign wr_mcycleh   = csrDestinationEnable && (destinationCSR == A_MCYCLEH);
   assign wr_minstret  = csrDestinationEnable && (destinationCSR == A_MINSTRET);
   assign wr_minstreth = csrDestinationEnable && (destinationCSR == A_MINSTRETH);

   // events; trapType is one-hot by value so EXCEPTION > MRET falls out,
   // and an interrupt only lands on an instruction retiring normally
   logic take_exc;
   logic take_mret;
   logic take_irq;
   logic take_trap;
   logic take_any;

   assign take_exc  = memoryWritebackValid && (trap_type == T_EXCEPTION);
   assign take_mret = memoryWritebackValid && (trap_type == T_MRET);
   assign take_irq  = memoryWritebackValid && (trap_type == T_NONE) &&
                      mstatus_mie && mie_meie && interrupt;
   assign take_trap = take_exc || take_irq;
   assign take_any  = take_trap || take_mret;

   // mstatus: trap/MRET updates override any same-cycle software write
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mstatus_mie  <= 1'b0;
         mstatus_mpie <= 1'b0;
      end else if (take_trap) begin
         mstatus_mpie <= mstatus_mie;
         mstatus_mie  <= 1'b0;
      end else if (take_mret) begin
         mstatus_mie  <= mstatus_mpie;
         mstatus_mpie <= 1'b1;
      end else if (wr_mstatus) begin
         mstatus_mie  <= csrWriteData[3];
         mstatus_mpie <= csrWriteData[7];
      end
   end

   // software-only registers: mie, mtvec, mscratch
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mie_meie   <= 1'b0;
         mtvec_base <= 30'd0;
         mscratch   <= 32'd0;
      end else begin
         if (wr_mie)      mie_meie   <= csrWriteData[11];
         if (wr_mtvec)    mtvec_base <= csrWriteData[31:2];
         if (wr_mscratch) mscratch   <= csrWriteData;
      end
   end

   // trap capture registers; trap entry wins, MRET leaves them to software
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mepc_word <= 30'd0;
         mcause    <= 32'd0;
         mtval     <= 32'd0;
      end else if (take_exc) begin
         mepc_word <= trap_pc[31:2];
         mcause    <= {28'd0, trap_cause};
         mtval     <= trap_tval;
      end else if (take_irq) begin
         mepc_word <= next_pc_word;
         mcause    <= IRQ_CAUSE;
         mtval     <= 32'd0;
      end else begin
         if (wr_mepc)   mepc_word <= csrWriteData[31:2];
         if (wr_mcause) mcause    <= csrWriteData;
         if (wr_mtval)  mtval     <= csrWriteData;
      end
   end

   // cycle counter: a write to either half replaces this cycle's increment
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mcycle <= 64'd0;
      end else if (wr_mcycle) begin
         mcycle[31:0] <= csrWriteData;
      end else if (wr_mcycleh) begin
         mcycle[63:32] <= csrWriteData;
      end else begin
         mcycle <= mcycle + 64'd1;
      end
   end

   // retired-instruction counter: a write wins over the retirement increment
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         minstret <= 64'd0;
      end else if (wr_minstret) begin
         minstret[31:0] <= csrWriteData;
      end else if (wr_minstreth) begin
         minstret[63:32] <= csrWriteData;
      end else if (dualValid) begin
         minstret <= minstret + 64'd1;
      end
   end

   // fetch redirect: one-cycle pulse that never stretches into a second cycle
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         redirectValid <= 1'b0;
         redirectPC    <= 32'd0;
      end else begin
         redirectValid <= take_any && !redirectValid;
         if (take_any && !redirectValid) begin
            redirectPC <= take_trap ? {mtvec_base, 2'b00} : {mepc_word, 2'b00};
         end
      end
   end

   // decode read port, straight from current state
   always_comb begin
      readData = 32'd0;
      case (readCSR)
         A_MSTATUS:   readData = {19'd0, 2'b11, 3'd0, mstatus_mpie, 3'd0, mstatus_mie, 3'd0};
         A_MISA:      readData = MISA_VALUE;
         A_MIE:       readData = {20'd0, mie_meie, 11'd0};
         A_MTVEC:     readData = {mtvec_base, 2'b00};
         A_MSCRATCH:  readData = mscratch;
         A_MEPC:      readData = {mepc_word, 2'b00};
         A_MCAUSE:    readData = mcause;
         A_MTVAL:     readData = mtval;
         A_MIP:       readData = {20'd0, interrupt, 11'd0};
         A_MCYCLE:    readData = mcycle[31:0];
         A_MCYCLEH:   readData = mcycle[63:32];
         A_MINSTRET:  readData = minstret[31:0];
         A_MINSTRETH: readData = minstret[63:32];
         A_MHARTID:   readData = HART_ID;
         default:     readData = 32'd0;
      endcase
   end

endmodule
